// File: rtl/hex_display_driver.sv
// Multi-digit hex-to-seven-segment driver: captures a packed value, decodes it MS digit first
// with optional leading-zero blanking, commits all digits at once, and supports whole-display blink.
module hex_display_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    ready,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [4*NUM_DIGITS-1:0] val_reg;
  logic                    lz_active;
  logic [IDX_W-1:0]        idx;
  logic [7*NUM_DIGITS-1:0] shadow;
  logic [7*NUM_DIGITS-1:0] seg_reg;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    phase;
  logic [3:0]              cur_digit;
  logic                    blank_cur;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    cur_digit = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) cur_digit = val_reg[4*k +: 4];
    end
  end

  // The least significant digit always shows, so an all-zero value still reads "0".
  assign blank_cur = lz_active && (cur_digit == 4'h0) && (idx != '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (idx == '0) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (load) begin
          val_reg   <= value_in;
          lz_active <= blank_lz;
          idx       <= IDX_TOP;
        end
      end
      CONVERT: begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (idx == IDX_W'(k)) shadow[7*k +: 7] <= blank_cur ? SEG_BLANK : hex_to_seg(cur_digit);
        end
        if (!blank_cur) lz_active <= 1'b0;
        if (idx != '0) idx <= idx - IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Segment outputs change only here, so a partially converted value is never displayed.
  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      seg_reg <= '1;
    end else begin
      done <= (state == COMMIT);
      if (state == COMMIT) seg_reg <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == CNT_TOP) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  assign seg_out = (blink_en && !phase) ? '1 : seg_reg;

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver (4 digits, blink half-period 4 cycles) with a
// scoreboard of committed display values and a reference model of the blink phase.
module tb_hex_display_driver;

  localparam int ND = 4;
  localparam int BD = 4;
  localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = 16'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        ready;
  logic        done;
  logic [27:0] seg_out;

  int          n_assert = 0;
  int          n_fail = 0;
  int          mcnt = 0;
  logic        mph = 1'b1;
  logic [27:0] exp_q[$];

  always #5 clk = ~clk;

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .load     (load),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .ready    (ready),
    .done     (done),
    .seg_out  (seg_out)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] model(input logic [15:0] v, input logic blz);
    logic [27:0] r;
    logic        lz;
    lz = blz;
    r  = '1;
    for (int k = ND - 1; k >= 0; k--) begin
      if (lz && v[4*k +: 4] == 4'h0 && k != 0) r[7*k +: 7] = 7'h7F;
      else begin
        r[7*k +: 7] = enc(v[4*k +: 4]);
        lz = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [27:0] visible(input logic [27:0] s);
    return (blink_en && !mph) ? ALL_OFF : s;
  endfunction

  // Advance one clock; the blink reference model tracks the same edge.
  task automatic tick();
    logic rst_s;
    rst_s = reset;
    @(posedge clk);
    if (rst_s) begin
      mcnt = 0;
      mph  = 1'b1;
    end else if (mcnt == BD - 1) begin
      mcnt = 0;
      mph  = ~mph;
    end else begin
      mcnt++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_commit(input string tag, input int lat_exp, input int c0);
    int c;
    logic [27:0] e;
    c = c0;
    while (done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_latency"}, c, lat_exp);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_seg"}, {4'h0, seg_out}, {4'h0, visible(e)});
    end
    chk({tag, "_ready_at_done"}, {31'h0, ready}, 1);
    tick();
    chk({tag, "_done_one_cycle"}, {31'h0, done}, 0);
  endtask

  task automatic do_load(input string tag, input logic [15:0] v, input logic blz,
                         input logic [27:0] e);
    chk({tag, "_ready_before"}, {31'h0, ready}, 1);
    value_in = v;
    blank_lz = blz;
    load     = 1'b1;
    tick();
    load = 1'b0;
    exp_q.push_back(e);
    chk({tag, "_busy"}, {31'h0, ready}, 0);
    wait_commit(tag, ND + 1, 0);
  endtask

  initial begin
    logic [27:0] e8;
    int          guard;

    // 1: reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_seg", {4'h0, seg_out}, {4'h0, ALL_OFF});
    chk("rst_ready", {31'h0, ready}, 1);
    chk("rst_done", {31'h0, done}, 0);
    reset = 1'b0;
    tick();

    // 2: plain decode, fixed latency
    do_load("t2_1A3F", 16'h1A3F, 1'b0, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110});

    // 3: leading-zero blanking, digit 0 always lit
    do_load("t3_0050", 16'h0050, 1'b1, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000});
    do_load("t3_0000", 16'h0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
    do_load("t3_0050_nolz", 16'h0050, 1'b0, model(16'h0050, 1'b0));

    // 4: load while busy is dropped
    chk("t4_ready_before", {31'h0, ready}, 1);
    value_in = 16'h1234;
    blank_lz = 1'b0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    exp_q.push_back(model(16'h1234, 1'b0));
    tick();
    chk("t4_busy", {31'h0, ready}, 0);
    value_in = 16'h5678;
    load     = 1'b1;
    tick();
    load = 1'b0;
    wait_commit("t4_1234", ND + 1, 2);
    for (int i = 0; i < 6; i++) begin
      chk("t4_no_second_done", {31'h0, done}, 0);
      chk("t4_hold_1234", {4'h0, seg_out}, {4'h0, model(16'h1234, 1'b0)});
      tick();
    end
    do_load("t4_5678", 16'h5678, 1'b0, model(16'h5678, 1'b0));

    // 5: blink
    e8 = model(16'h8888, 1'b0);
    do_load("t5_8888", 16'h8888, 1'b0, e8);
    blink_en = 1'b1;
    #1;
    chk("t5_blink_on", {4'h0, seg_out}, {4'h0, visible(e8)});
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t5_blink_cycle", {4'h0, seg_out}, {4'h0, visible(e8)});
    end
    guard = 0;
    while (mph !== 1'b0 && guard < 8) begin
      tick();
      guard++;
    end
    chk("t5_blank_phase_seen", {31'h0, mph}, 0);
    chk("t5_blanked", {4'h0, seg_out}, {4'h0, ALL_OFF});
    blink_en = 1'b0;
    #1;
    chk("t5_blink_off_now", {4'h0, seg_out}, {4'h0, e8});
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_held", {4'h0, seg_out}, {4'h0, e8});
    end
    // commit while blinking: new value appears in the next visible phase
    blink_en = 1'b1;
    do_load("t5_commit_blink", 16'h1A3F, 1'b0, model(16'h1A3F, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_blink_new", {4'h0, seg_out}, {4'h0, visible(model(16'h1A3F, 1'b0))});
    end
    blink_en = 1'b0;
    tick();

    // 6: reset during conversion aborts
    chk("t6_ready_before", {31'h0, ready}, 1);
    value_in = 16'h4321;
    load     = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("t6_busy", {31'h0, ready}, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_seg_blank", {4'h0, seg_out}, {4'h0, ALL_OFF});
    chk("t6_done_low", {31'h0, done}, 0);
    tick();
    chk("t6_ready_after", {31'h0, ready}, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t6_no_done", {31'h0, done}, 0);
      chk("t6_still_blank", {4'h0, seg_out}, {4'h0, ALL_OFF});
      tick();
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
